// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: synchronizes and debounces two push-buttons and turns each
// debounced press into a single-cycle, mutually exclusive S or R pulse.
module sr_cmd_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit PRIORITY_SET    = 1'b0,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_btn,
   input  logic             clr_btn,
   output logic             S,
   output logic             R,
   output logic             conflict,
   output logic [CNT_W-1:0] set_cnt,
   output logic [CNT_W-1:0] clr_cnt
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

   // bit 0 = set channel, bit 1 = clr channel
   logic [1:0]    btn;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    db;
   logic [1:0]    qual;
   logic [1:0]    press;
   logic [DW-1:0] dcnt [2];

   logic s_nxt;
   logic r_nxt;
   logic c_nxt;

   assign btn = {clr_btn, set_btn};

   always_comb begin
      qual = '0;
      for (int i = 0; i < 2; i++) begin
         qual[i] = (sync2[i] != db[i]) && (dcnt[i] == DLAST);
      end
      press = qual & sync2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int i = 0; i < 2; i++) begin
            dcnt[i] <= '0;
         end
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DLAST) begin
               db[i]   <= sync2[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + DW'(1);
            end
         end
      end
   end

   always_comb begin
      s_nxt = 1'b0;
      r_nxt = 1'b0;
      c_nxt = 1'b0;
      unique case (press)
         2'b01: s_nxt = 1'b1;
         2'b10: r_nxt = 1'b1;
         2'b11: begin
            s_nxt = PRIORITY_SET;
            c_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         S        <= 1'b0;
         R        <= 1'b0;
         conflict <= 1'b0;
         set_cnt  <= '0;
         clr_cnt  <= '0;
      end else begin
         S        <= s_nxt;
         R        <= r_nxt;
         conflict <= c_nxt;
         if (s_nxt) set_cnt <= set_cnt + CNT_W'(1);
         if (r_nxt) clr_cnt <= clr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Upstream command stage for the SR flip-flop. It takes two raw, asynchronous push-button inputs (set and clear), synchronizes and debounces them, and converts each debounced press into a single-cycle `S` or `R` pulse that drives the flip-flop's `S`/`R` inputs directly. `S` and `R` are never asserted together, so the flip-flop's invalid `{S,R}=11` case can never be reached. Simultaneous presses are resolved here, and emitted pulses are counted for debug.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles an input must differ from its debounced state before that state updates; legal range ≥1.
- `PRIORITY_SET`, default 0: 0 = simultaneous presses emit nothing and flag a conflict; 1 = simultaneous presses emit `S` only and flag a conflict.
- `CNT_W`, default 8: width of the pulse counters.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `set_btn` input 1: raw set button, asynchronous, may bounce.
- `clr_btn` input 1: raw clear button, asynchronous, may bounce.
- `S` output 1: one-cycle set pulse to the flip-flop; registered.
- `R` output 1: one-cycle reset pulse to the flip-flop; registered.
- `conflict` output 1: one-cycle flag when both presses qualify on the same edge; registered.
- `set_cnt` output CNT_W: number of `S` pulses emitted; wraps.
- `clr_cnt` output CNT_W: number of `R` pulses emitted; wraps.

## Operation
- **Per channel (set, clr), identical logic:**
  - Synchronizer: two-flop chain `sync1 → sync2`.
  - Debounce state `db`, reset 0.
  - Counter `dcnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, reset 0.
- **Debounce rule, evaluated each edge:**
  - If `sync2 == db`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `db <= sync2`, `dcnt <= 0`. This is a qualify event.
  - Else: `dcnt <= dcnt+1`.
- **Press event:** a qualify event with `sync2 == 1` (0→1 transition of `db`). Release events (1→0) update `db` but produce no pulse.
- **Output arbitration, on each edge:**
  - Set press only: `S <= 1`, `set_cnt <= set_cnt+1`.
  - Clr press only: `R <= 1`, `clr_cnt <= clr_cnt+1`.
  - Both presses, `PRIORITY_SET=0`: `S <= 0`, `R <= 0`, `conflict <= 1`; no counter changes.
  - Both presses, `PRIORITY_SET=1`: `S <= 1`, `R <= 0`, `conflict <= 1`, `set_cnt` increments.
  - Otherwise: `S`, `R` and `conflict` return to 0.
- **Invariants:** `S & R == 0` on every cycle. Each output pulse lasts exactly one cycle. A held button yields exactly one pulse.
- **Counters:** modulo 2^CNT_W; `2^CNT_W-1` wraps to 0 on the next pulse.
- **Reset values:** `S`, `R`, `conflict` = 0; `set_cnt`, `clr_cnt` = 0; all sync flops, `db` and `dcnt` = 0.
- **Reset mid-operation:** any in-progress debounce count is discarded. A button still held when `rst` deasserts counts as a fresh press and produces one pulse after the full latency.
- **Bounce:** any excursion lasting fewer than `DEBOUNCE_CYCLES` synchronized cycles leaves `db` unchanged and emits no pulse.

## Timing
- **Press latency:** `set_btn` goes high before edge 0 and stays stable. Then:
  - `sync2` = 1 after edge 1.
  - `db` rises at edge `1+DEBOUNCE_CYCLES`.
  - `S` is high for the cycle after edge `1+DEBOUNCE_CYCLES` and low again after edge `2+DEBOUNCE_CYCLES`.
  - For the default of 4: `S` goes high after edge 5.
- **Release latency:** same as press latency; no output activity.
- **Minimum press spacing:** two separate pulses need at least `DEBOUNCE_CYCLES` cycles low between presses, plus the synchronizer delay.
- **Reset:** `rst` high at an edge forces all reset values at that edge, overriding any event on the same edge.
- **Throughput:** at most one pulse per channel per press; combined output rate is at most one pulse per cycle.

## Test plan
- **Clean press** (D=4): hold `set_btn` high 20 cycles from edge 0 → `S`=1 only during the cycle after edge 5; `set_cnt`=1; `R`=0 throughout.
- **Bounce rejection:** `clr_btn` toggles high 2 cycles, low 1, high 3, then stays high → exactly one `R` pulse, 5 edges after the final stable rise reaches `sync1`; no pulse from the glitches.
- **Simultaneous press:** both buttons rise on the same edge, held. With `PRIORITY_SET=0` → `S`=`R`=0 and `conflict`=1 for one cycle, counters unchanged. With `PRIORITY_SET=1` → `S`=1, `R`=0, `conflict`=1, `set_cnt`=1.
- **Offset presses:** clr rises 1 cycle after set → `S` pulse, then `R` pulse one cycle later; `conflict` never asserts; `S & R` never both 1.
- **Counter wrap** (CNT_W=2): 5 separate set presses → `set_cnt` sequence 1, 2, 3, 0, 1.
- **Reset mid-debounce:** `rst` high for 1 cycle, 2 cycles into a set press, with the button held → no pulse before reset; one `S` pulse after the full post-reset latency; counters 0 before that pulse.
